// File: rtl/div_if.sv
// div_if: request/response bundle between the EX stage and the multi-cycle divider
// Ports (master = pipeline side, slave = divider side):
//   start, op[1:0], dividend, divisor, flush : master -> slave
//   busy, done, result                       : slave -> master
interface div_if #(parameter int XLEN = 32);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   modport master (output start, op, dividend, divisor, flush, input busy, done, result);
   modport slave  (input start, op, dividend, divisor, flush, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_if.slave -- start/op/dividend/divisor/flush in, busy/done/result out (all registered)
module div_unit #(parameter int XLEN = 32) (
   input logic  clk,
   input logic  rst_n,
   div_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t          state;
   logic [1:0]      op_q;
   logic            sgn_a, sgn_b, busy_q, done_q;
   logic [XLEN-1:0] rem, quo, dvs, res_q;
   logic [CW-1:0]   cnt;
   logic            is_signed, div0, ovf, neg_q, neg_r;
   logic [XLEN-1:0] mag_a, mag_b, spec_res, fix_res;
   logic [XLEN:0]   sh, diff;
   assign is_signed = ~bus.op[0];
   assign mag_a     = is_signed && bus.dividend[XLEN-1] ? -bus.dividend : bus.dividend;
   assign mag_b     = is_signed && bus.divisor[XLEN-1] ? -bus.divisor : bus.divisor;
   assign div0      = bus.divisor == '0;
   assign ovf       = is_signed && bus.dividend == {1'b1, {(XLEN-1){1'b0}}} && &bus.divisor;
   // on overflow the dividend itself is the most-negative quotient
   assign spec_res  = div0 ? (bus.op[1] ? bus.dividend : '1) : (bus.op[1] ? '0 : bus.dividend);
   // the stored remainder is always below the divisor, so it fits XLEN bits; the
   // shifted value needs one extra bit and the borrow of the trial subtract is diff[XLEN]
   assign sh        = {rem, quo[XLEN-1]};
   assign diff      = sh - {1'b0, dvs};
   assign neg_q     = op_q == 2'b00 && (sgn_a ^ sgn_b);
   assign neg_r     = op_q == 2'b10 && sgn_a;
   assign fix_res   = op_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = res_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= '0;
         sgn_a  <= 1'b0;
         sgn_b  <= 1'b0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         res_q  <= '0;
      end else if (bus.flush) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op_q  <= bus.op;
               sgn_a <= is_signed & bus.dividend[XLEN-1];
               sgn_b <= is_signed & bus.divisor[XLEN-1];
               rem   <= '0;
               quo   <= mag_a;
               dvs   <= mag_b;
               cnt   <= CW'(XLEN-1);
               if (div0 || ovf) begin
                  res_q  <= spec_res;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  busy_q <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               rem <= diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
               quo <= {quo[XLEN-2:0], ~diff[XLEN]};
               cnt <= cnt - CW'(1);
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               res_q  <= fix_res;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (directed cases, handshake corners, random vs. model)
module tb_div_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   div_if #(.XLEN(32)) bus();
   div_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {logic [1:0] op; logic [31:0] a, b, exp; int lat;} vec_t;
   vec_t        v[$];
   logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   // RV32M rules with plain arithmetic; SV signed division truncates toward zero like RISC-V
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      case (o)
         2'd0: return $signed(a) / $signed(b);
         2'd1: return a / b;
         2'd2: return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction
   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
   endfunction
   task automatic wait_done(output logic [31:0] r, output int n, output int nb, output logic ovl);
      r = 'x; n = 0; nb = 0; ovl = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ovl |= bus.busy & bus.done;
         if (bus.done) begin
            r = bus.result;
            n = i + 1;
            break;
         end
         if (bus.busy) nb++;
      end
   endtask
   task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.op = o; bus.dividend = a; bus.divisor = b;
   endtask
   task automatic do_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int n, output int nb, output logic ovl);
      @(negedge clk);
      drive(o, a, b);
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(r, n, nb, ovl);
   endtask
   function automatic logic [31:0] pick();
      case ($urandom_range(0, 3))
         0: return corner[$urandom_range(0, 5)];
         1: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction
   initial begin
      logic [31:0] r, a, b;
      logic [1:0]  o;
      int          n, nb;
      logic        ovl;
      bus.start = 1'b0; bus.op = '0; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_result", bus.result, 0);
      @(negedge clk) rst_n = 1'b1;
      v = '{
         '{2'd0, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34},
         '{2'd2, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, 34},
         '{2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34},
         '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34},
         '{2'd0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34},
         '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34},
         '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34},
         '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34},
         '{2'd0, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1},
         '{2'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1},
         '{2'd1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1},
         '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1},
         '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
         '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
      };
      foreach (v[i]) begin
         do_req(v[i].op, v[i].a, v[i].b, r, n, nb, ovl);
         chk($sformatf("dir%0d_result", i), r, v[i].exp);
         chk($sformatf("dir%0d_latency", i), 32'(n), 32'(v[i].lat));
         chk($sformatf("dir%0d_busy_cycles", i), 32'(nb), v[i].lat == 34 ? 33 : 0);
         chk($sformatf("dir%0d_busy_done_overlap", i), 32'(ovl), 0);
      end
      // start pulsed at E5 while busy must be ignored
      @(negedge clk);
      drive(2'd0, 32'h0000_0014, 32'hFFFF_FFFD);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 drive(2'd1, 32'h1, 32'h1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(r, n, nb, ovl);
      chk("ignore_result", r, 32'hFFFF_FFFA);
      chk("ignore_latency_after_e5", 32'(n), 29);
      do_req(2'd2, 32'h0000_0014, 32'hFFFF_FFFD, r, n, nb, ovl);
      chk("b2b_result", r, 32'h0000_0002);
      chk("b2b_latency", 32'(n), 34);
      // flush at E10 aborts with no done and result held
      @(negedge clk);
      drive(2'd1, 32'hFFFF_FFFF, 32'h3);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      chk("flush_busy", 32'(bus.busy), 0);
      chk("flush_done", 32'(bus.done), 0);
      wait_done(r, n, nb, ovl);
      chk("flush_no_done", 32'(n), 0);
      chk("flush_result_held", bus.result, 32'h0000_0002);
      // flush beats start in IDLE
      @(negedge clk);
      drive(2'd0, 32'h1234_5678, 32'h0);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.flush = 1'b0;
      wait_done(r, n, nb, ovl);
      chk("flush_start_no_done", 32'(n), 0);
      chk("flush_start_result_held", bus.result, 32'h0000_0002);
      // asynchronous reset at E20 of a request
      @(negedge clk);
      drive(2'd0, 32'h0000_0064, 32'h7);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("pre_reset_busy", 32'(bus.busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(bus.busy), 0);
      chk("async_rst_done", 32'(bus.done), 0);
      chk("async_rst_result", bus.result, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         do_req(o, a, b, r, n, nb, ovl);
         chk($sformatf("rand op%0d %h/%h", o, a, b), r, ref_div(o, a, b));
         chk($sformatf("rand_lat op%0d %h/%h", o, a, b), 32'(n), 32'(ref_lat(o, a, b)));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
